// File: rtl/imem_port_arbiter.sv
// Shares the byte-wide instruction-memory port between CPU fetch (4-byte big-endian words)
// and the loader/debug port (single bytes), round-robin. Optional macro: IMEM_ALIGN_CHECK_EN.
module imem_port_arbiter #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_done,
    output logic [31:0]       f_rdata,
    output logic              f_err,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [7:0]        l_wdata,
    output logic              l_done,
    output logic [7:0]        l_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD} state_t;

    state_t            state;
    logic              last_l;
    logic [1:0]        k;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [7:0]        wdata_q;
    logic [23:0]       shift_q;
    logic              grant_f;
    logic              grant_l;
    logic              misalign;

`ifdef IMEM_ALIGN_CHECK_EN
    assign misalign = (f_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // On a tie the requester that was not served last wins.
    assign grant_f = f_req & (~l_req | last_l);
    assign grant_l = l_req & (~f_req | ~last_l);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            last_l  <= 1'b1;
            k       <= 2'd0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= 8'd0;
            shift_q <= 24'd0;
            f_rdata <= 32'd0;
            f_done  <= 1'b0;
            f_err   <= 1'b0;
            l_rdata <= 8'd0;
            l_done  <= 1'b0;
        end else begin
            f_done <= 1'b0;
            f_err  <= 1'b0;
            l_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_f) begin
                        last_l <= 1'b0;
                        addr_q <= f_addr;
                        k      <= 2'd0;
                        if (misalign) begin
                            f_done  <= 1'b1;
                            f_err   <= 1'b1;
                            f_rdata <= 32'd0;
                        end else begin
                            state <= FETCH;
                        end
                    end else if (grant_l) begin
                        last_l  <= 1'b1;
                        addr_q  <= l_addr;
                        we_q    <= l_we;
                        wdata_q <= l_wdata;
                        state   <= LOAD;
                    end
                end
                FETCH: begin
                    k <= k + 2'd1;
                    // Beat k lands in byte lane 3-k; the last byte completes the word directly.
                    case (k)
                        2'd0: shift_q[23:16] <= mem_rdata;
                        2'd1: shift_q[15:8]  <= mem_rdata;
                        2'd2: shift_q[7:0]   <= mem_rdata;
                        default: begin
                            f_rdata <= {shift_q, mem_rdata};
                            f_done  <= 1'b1;
                            state   <= IDLE;
                        end
                    endcase
                end
                LOAD: begin
                    if (!we_q) l_rdata <= mem_rdata;
                    l_done <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory strobes decode from registered state only, so reset kills a write at once.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = 8'd0;
        case (state)
            FETCH: mem_addr = addr_q + ADDR_W'(k);
            LOAD: begin
                mem_addr  = addr_q;
                mem_we    = we_q;
                mem_wdata = wdata_q;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural 32 KiB byte memory.
module tb_imem_port_arbiter;

    localparam int ADDR_W = 15;

    logic              clk;
    logic              rst_n;
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_done;
    logic [31:0]       f_rdata;
    logic              f_err;
    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [7:0]        l_wdata;
    logic              l_done;
    logic [7:0]        l_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              busy;

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    int passes;
    int total;
    int nd;
    int exp_fl [14];

    imem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata), .f_err(f_err),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_done(l_done), .l_rdata(l_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        passes = 0;
        total  = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
        mem[0] = 8'h20; mem[1] = 8'h08; mem[2] = 8'h00; mem[3] = 8'h05;
        mem[15'h7FFE] = 8'h11; mem[15'h7FFF] = 8'h22;
        exp_fl = '{0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0, 2, 0, 1};

        rst_n = 1'b0; f_req = 1'b0; f_addr = '0;
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = 8'd0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_outs", {f_done, f_err, l_done, l_rdata}, 32'd0);
        chk("rst_f_rdata", f_rdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Aligned fetch at 0x0000
        f_req = 1'b1; f_addr = 15'h0000;
        tick();
        chk("f0_busy", 32'(busy), 32'd1);
        chk("f0_addr0", 32'(mem_addr), 32'h0);
        f_addr = 15'h0100;
        tick(); chk("f0_addr1", 32'(mem_addr), 32'h1);
        tick(); chk("f0_addr2", 32'(mem_addr), 32'h2);
        tick(); chk("f0_addr3", 32'(mem_addr), 32'h3);
        chk("f0_not_done_early", 32'(f_done), 32'd0);
        tick();
        chk("f0_done", 32'(f_done), 32'd1);
        chk("f0_rdata", f_rdata, 32'h20080005);
        chk("f0_err", 32'(f_err), 32'd0);
        chk("f0_idle", 32'(busy), 32'd0);
        f_req = 1'b0;
        tick();
        chk("f0_done_pulse", 32'(f_done), 32'd0);
        chk("f0_rdata_hold", f_rdata, 32'h20080005);

        // Loader write 0xAB to 0x0010
        l_req = 1'b1; l_we = 1'b1; l_addr = 15'h0010; l_wdata = 8'hAB;
        tick();
        chk("lw_we", 32'(mem_we), 32'd1);
        chk("lw_addr", 32'(mem_addr), 32'h10);
        l_wdata = 8'h55;
        #1;
        chk("lw_wdata_latched", 32'(mem_wdata), 32'hAB);
        tick();
        chk("lw_done", 32'(l_done), 32'd1);
        chk("lw_we_off", 32'(mem_we), 32'd0);
        l_req = 1'b0;
        tick();
        chk("lw_mem", 32'(mem[16]), 32'hAB);

        // Loader read back 0x0010
        l_req = 1'b1; l_we = 1'b0;
        tick();
        chk("lr_we", 32'(mem_we), 32'd0);
        chk("lr_busy", 32'(busy), 32'd1);
        tick();
        chk("lr_done", 32'(l_done), 32'd1);
        chk("lr_rdata", 32'(l_rdata), 32'hAB);
        l_req = 1'b0;
        tick();
        chk("lr_rdata_hold", 32'(l_rdata), 32'hAB);

        // Both requesters held after a fresh reset: F, L, F, L
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        f_req = 1'b1; f_addr = 15'h0000; l_req = 1'b1; l_we = 1'b0; l_addr = 15'h0010;
        for (int i = 0; i < 14; i++) begin
            tick();
            chk($sformatf("rr_cyc%0d", i + 1), 32'({f_done, l_done}), 32'(exp_fl[i]));
        end
        f_req = 1'b0; l_req = 1'b0;
        chk("rr_f_rdata", f_rdata, 32'h20080005);
        tick();
        tick();
        chk("rr_idle", 32'(busy), 32'd0);

        // Fetch at 0x7FFE: wraps, or rejected when alignment checking is built in
        f_req = 1'b1; f_addr = 15'h7FFE;
`ifdef IMEM_ALIGN_CHECK_EN
        tick();
        chk("mis_busy", 32'(busy), 32'd0);
        chk("mis_done", 32'(f_done), 32'd1);
        chk("mis_err", 32'(f_err), 32'd1);
        chk("mis_rdata", f_rdata, 32'd0);
        f_req = 1'b0;
        tick();
        chk("mis_err_pulse", 32'(f_err), 32'd0);
`else
        tick(); chk("wr_addr0", 32'(mem_addr), 32'h7FFE);
        tick(); chk("wr_addr1", 32'(mem_addr), 32'h7FFF);
        tick(); chk("wr_addr2", 32'(mem_addr), 32'h0000);
        tick(); chk("wr_addr3", 32'(mem_addr), 32'h0001);
        tick();
        chk("wr_done", 32'(f_done), 32'd1);
        chk("wr_rdata", f_rdata, 32'h11222008);
        chk("wr_err", 32'(f_err), 32'd0);
        f_req = 1'b0;
        tick();
`endif

        // Reset during beat 2 of a fetch, then re-issue
        f_req = 1'b1; f_addr = 15'h0000;
        tick(); tick(); tick();
        chk("rb_beat2_addr", 32'(mem_addr), 32'h2);
        #1;
        rst_n = 1'b0; f_req = 1'b0;
        #1;
        chk("rb_busy", 32'(busy), 32'd0);
        chk("rb_addr", 32'(mem_addr), 32'd0);
        chk("rb_f_rdata", f_rdata, 32'd0);
        #2;
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (f_done) nd++;
        end
        chk("rb_no_done", 32'(nd), 32'd0);
        f_req = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        chk("rb_reissue_done", 32'(f_done), 32'd1);
        chk("rb_reissue_rdata", f_rdata, 32'h20080005);
        f_req = 1'b0;
        tick();

        // Reset in the LOAD cycle of a write
        l_req = 1'b1; l_we = 1'b1; l_addr = 15'h0020; l_wdata = 8'h77;
        tick();
        chk("lrst_we_on", 32'(mem_we), 32'd1);
        #1;
        rst_n = 1'b0; l_req = 1'b0;
        #1;
        chk("lrst_we_off", 32'(mem_we), 32'd0);
        #2;
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (l_done) nd++;
        end
        chk("lrst_no_done", 32'(nd), 32'd0);
        chk("lrst_mem_untouched", 32'(mem[32]), 32'h00);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
